dac_wave_gen: RTL and testbench
===============================

Name: dac_wave_gen

Overview:
- Upstream stage of the parallel 8-bit DAC write sequencer. Generates a periodic stream of DAC codes: constant, sawtooth, triangle or square.
- Delivers each code over a valid/ready handshake. The downstream write sequencer raises smp_ready when it has latched the code for its next WR cycle.
- The sample rate is set by a programmable clock divider. Lost samples are flagged, not queued.

Parameters:
- DW, 8, DAC code width (smp_data, step, level).
- PW, 16, width of the sample-period divider.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  1 = generate samples; 0 = divider held, no new samples
- mode  in  2  00 const, 01 sawtooth, 10 triangle, 11 square
- step  in  DW  amplitude increment per sample (sawtooth/triangle)
- level  in  DW  const output value; square high value
- period  in  PW  clocks per sample; 0 treated as 1
- smp_ready  in  1  downstream accepts smp_data this cycle
- smp_valid  out  1  smp_data holds an unaccepted sample
- smp_data  out  DW  current DAC code
- overrun  out  1  sticky: a sample tick was dropped

Behaviour:
- Reset, synchronous, active-high, applies on any cycle including mid-handshake:
  - smp_valid=0, smp_data=8'h80 (midscale), overrun=0.
  - Phase accumulator acc=8'h80, direction=up, square phase=high.
  - Divider count=0, mode_q=mode.
- Divider:
  - en=1: count increments each clock. When count == max(period,1)-1, assert internal tick for one cycle and clear count.
  - Sample interval is exactly max(period,1) clocks. period=1 and period=0 both give a tick every clock.
  - en=0: count forced to 0, no ticks. A pending handshake still completes.
  - Changes to period take effect on the following compare.
- Next-code computation on tick; all arithmetic is DW-bit unsigned.
  - const: code=level.
  - sawtooth: acc=acc+step, mod 2^DW wrap (8'hF0 + 8'h20 -> 8'h10). code=acc.
  - triangle, direction up: if acc+step >= 255 (computed DW+1 bits wide), acc=255 and direction flips to down; else acc=acc+step.
  - triangle, direction down: if acc <= step, acc=0 and direction flips to up; else acc=acc-step. code=acc.
  - square: emits level when phase=high, 0 when phase=low. Phase toggles every tick.
  - step=0 in sawtooth/triangle holds acc constant; no error.
- Mode change: when mode != mode_q at a tick, reload acc=0, direction=up, phase=high before computing the code. mode_q updates on that tick only.
- Output handshake, registered; latency is one clock from tick to smp_valid/smp_data:
  - tick and (smp_valid=0 or smp_ready=1): smp_data<=code, smp_valid<=1.
  - no tick and smp_valid=1 and smp_ready=1: smp_valid<=0; smp_data holds its last value.
  - tick and smp_valid=1 and smp_ready=0: sample dropped. acc/phase still advance, so waveform timing is preserved. overrun<=1. smp_data unchanged.
  - While smp_valid=1 and smp_ready=0, smp_data is stable.
  - smp_ready while smp_valid=0 is ignored.
- overrun clears only on rst.

Test Plan:
- Reset value: assert rst for 3 clocks, mid-stream with smp_valid=1 -> next cycle smp_valid=0, smp_data=8'h80, overrun=0.
- Sawtooth wrap: mode=01, step=8'h40, period=4, smp_ready tied 1 -> smp_valid pulses every 4 clocks with codes 8'hC0, 8'h00, 8'h40, 8'h80, 8'hC0. First pulse occurs 4 clocks after en rises.
- Triangle saturation: mode=10, step=8'h50, period=1, ready=1 -> codes 50, A0, F0, FF, AF, 5F, 0F, 00, 50 (hex). Codes start from 00 because the mode change reloads acc.
- Square/const: mode=11, level=8'hC8, period=2 -> codes alternate C8, 00, C8. Then switch to mode=00 with level=8'h33 -> next code 33, held while constant.
- Backpressure/overrun: sawtooth, step=1, period=3, smp_ready=0 for 10 clocks -> smp_data frozen at first code and overrun=1 after the second tick. On ready=1, the accepted sample is the frozen code and the next emitted code reflects the two dropped ticks (skips by 3).
- en/period=0: period=0 with en=1 -> one tick per clock. Drop en for 5 clocks -> no new samples; pending sample still accepted on ready. Re-raise en -> first sample after max(period,1) clocks.

Source files
------------

// File: rtl/dac_wave_gen.sv
// dac_wave_gen: periodic DAC code generator (const / sawtooth / triangle / square)
// feeding a valid/ready handshake. The sample rate comes from a programmable
// clock divider. A tick that arrives while a sample is still waiting is
// dropped and flagged with a sticky overrun bit.
module dac_wave_gen #(
    parameter int unsigned DW = 8,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] step,
    input  logic [DW-1:0] level,
    input  logic [PW-1:0] period,
    input  logic          smp_ready,
    output logic          smp_valid,
    output logic [DW-1:0] smp_data,
    output logic          overrun
);

    typedef enum logic [1:0] {
        M_CONST = 2'b00,
        M_SAW   = 2'b01,
        M_TRI   = 2'b10,
        M_SQR   = 2'b11
    } mode_t;

    typedef enum logic { DIR_UP, DIR_DOWN } dir_t;
    typedef enum logic { PH_HIGH, PH_LOW } phase_t;

    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW:0]   FULL     = {1'b0, {DW{1'b1}}};

    logic [PW-1:0] count;
    logic [PW-1:0] pmax;
    logic          tick;

    logic [DW-1:0] acc, acc_base, acc_n;
    dir_t          dir, dir_base, dir_n;
    phase_t        phase, ph_base, ph_n;
    logic [1:0]    mode_q;
    logic [DW-1:0] code;
    logic [DW:0]   tri_sum;

    // Effective period (0 behaves as 1) and the divider tick.
    // The >= compare also ends a count that a shrinking period left above the
    // new terminal value, so period changes apply on the following compare.
    always_comb begin
        pmax = (period == '0) ? PW'(1) : period;
        tick = en && (count >= (pmax - PW'(1)));
    end

    // Sample-period divider: held at zero while disabled, cleared on each tick.
    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

    // Next code and next waveform state, applying the mode-change reload first.
    always_comb begin
        acc_base = acc;
        dir_base = dir;
        ph_base  = phase;
        if (mode != mode_q) begin
            acc_base = '0;
            dir_base = DIR_UP;
            ph_base  = PH_HIGH;
        end
        acc_n   = acc_base;
        dir_n   = dir_base;
        ph_n    = ph_base;
        code    = acc_base;
        tri_sum = {1'b0, acc_base} + {1'b0, step};
        case (mode_t'(mode))
            M_CONST: code = level;
            M_SAW: begin
                acc_n = acc_base + step;
                code  = acc_n;
            end
            M_TRI: begin
                if (dir_base == DIR_UP) begin
                    if (tri_sum >= FULL) begin
                        acc_n = '1;
                        dir_n = DIR_DOWN;
                    end else begin
                        acc_n = tri_sum[DW-1:0];
                    end
                end else begin
                    if (acc_base <= step) begin
                        acc_n = '0;
                        dir_n = DIR_UP;
                    end else begin
                        acc_n = acc_base - step;
                    end
                end
                code = acc_n;
            end
            M_SQR: begin
                code = (ph_base == PH_HIGH) ? level : '0;
                ph_n = (ph_base == PH_HIGH) ? PH_LOW : PH_HIGH;
            end
            default: code = acc_base;
        endcase
    end

    // Waveform state advances on every tick, even when the sample is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= MIDSCALE;
            dir    <= DIR_UP;
            phase  <= PH_HIGH;
            mode_q <= mode;
        end else if (tick) begin
            acc    <= acc_n;
            dir    <= dir_n;
            phase  <= ph_n;
            mode_q <= mode;
        end
    end

    // Output handshake register and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_valid <= 1'b0;
            smp_data  <= MIDSCALE;
            overrun   <= 1'b0;
        end else if (tick) begin
            if (!smp_valid || smp_ready) begin
                smp_data  <= code;
                smp_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (smp_valid && smp_ready) begin
            smp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: directed self-checking bench for dac_wave_gen.
module tb_dac_wave_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  step;
    logic [7:0]  level;
    logic [15:0] period;
    logic        smp_ready;
    logic        smp_valid;
    logic [7:0]  smp_data;
    logic        overrun;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0] saw_exp [5] = '{8'hC0, 8'h00, 8'h40, 8'h80, 8'hC0};
    logic [7:0] tri_exp [9] = '{8'h50, 8'hA0, 8'hF0, 8'hFF, 8'hAF, 8'h5F, 8'h0F, 8'h00, 8'h50};
    logic [7:0] sq_exp  [3] = '{8'hC8, 8'h00, 8'hC8};

    dac_wave_gen #(.DW(8), .PW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .level     (level),
        .period    (period),
        .smp_ready (smp_ready),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'b01; step = 8'h40; period = 16'd1; level = 8'h00; smp_ready = 1'b0;
        do_reset();
        en = 1'b1;
        repeat (3) cyc();
        tests++;
        if ({smp_valid, overrun} !== 2'b11) begin
            fails++; $display("FAIL reset_precond: valid/overrun=%b want 11", {smp_valid, overrun});
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if ({smp_valid, smp_data, overrun} !== {1'b0, 8'h80, 1'b0}) begin
                fails++;
                $display("FAIL reset_state[%0d]: valid=%b data=%h ovr=%b want 0 80 0", i, smp_valid, smp_data, overrun);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sawtooth();
        mode = 2'b01; step = 8'h40; period = 16'd4; smp_ready = 1'b1;
        do_reset();
        en = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (c < 4) begin
                    tests++;
                    if (smp_valid !== 1'b0) begin
                        fails++; $display("FAIL saw_gap[%0d.%0d]: valid=%b want 0", s, c, smp_valid);
                    end
                end else begin
                    tests++;
                    if ({smp_valid, smp_data} !== {1'b1, saw_exp[s]}) begin
                        fails++;
                        $display("FAIL saw_code[%0d]: valid=%b data=%h want 1 %h", s, smp_valid, smp_data, saw_exp[s]);
                    end
                end
            end
        end
    endtask

    task automatic test_triangle();
        mode = 2'b01; step = 8'h50; period = 16'd1; smp_ready = 1'b1;
        do_reset();
        mode = 2'b10;
        en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            cyc();
            tests++;
            if ({smp_valid, smp_data} !== {1'b1, tri_exp[s]}) begin
                fails++;
                $display("FAIL tri_code[%0d]: valid=%b data=%h want 1 %h", s, smp_valid, smp_data, tri_exp[s]);
            end
        end
    endtask

    task automatic test_square_const();
        mode = 2'b00; step = 8'h00; level = 8'hC8; period = 16'd2; smp_ready = 1'b1;
        do_reset();
        mode = 2'b11;
        en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            tests++;
            if ((c % 2) == 0) begin
                if ({smp_valid, smp_data} !== {1'b1, sq_exp[c/2-1]}) begin
                    fails++;
                    $display("FAIL sq_code[%0d]: valid=%b data=%h want 1 %h", c/2-1, smp_valid, smp_data, sq_exp[c/2-1]);
                end
            end else if (smp_valid !== 1'b0) begin
                fails++; $display("FAIL sq_gap[%0d]: valid=%b want 0", c, smp_valid);
            end
        end
        mode = 2'b00; level = 8'h33;
        cyc(); cyc();
        tests++;
        if ({smp_valid, smp_data} !== {1'b1, 8'h33}) begin
            fails++; $display("FAIL const_first: valid=%b data=%h want 1 33", smp_valid, smp_data);
        end
        cyc();
        tests++;
        if (smp_valid !== 1'b0) begin
            fails++; $display("FAIL const_gap: valid=%b want 0", smp_valid);
        end
        cyc();
        tests++;
        if ({smp_valid, smp_data} !== {1'b1, 8'h33}) begin
            fails++; $display("FAIL const_hold: valid=%b data=%h want 1 33", smp_valid, smp_data);
        end
    endtask

    task automatic test_back_to_back_overrun();
        mode = 2'b01; step = 8'h01; period = 16'd3; smp_ready = 1'b0;
        do_reset();
        en = 1'b1;
        repeat (3) cyc();
        tests++;
        if ({smp_valid, smp_data, overrun} !== {1'b1, 8'h81, 1'b0}) begin
            fails++;
            $display("FAIL bp_first: valid=%b data=%h ovr=%b want 1 81 0", smp_valid, smp_data, overrun);
        end
        repeat (2) cyc();
        tests++;
        if (overrun !== 1'b0) begin
            fails++; $display("FAIL bp_ovr_early: ovr=%b want 0", overrun);
        end
        cyc();
        tests++;
        if ({smp_valid, smp_data, overrun} !== {1'b1, 8'h81, 1'b1}) begin
            fails++;
            $display("FAIL bp_drop1: valid=%b data=%h ovr=%b want 1 81 1", smp_valid, smp_data, overrun);
        end
        repeat (4) cyc();
        smp_ready = 1'b1;
        tests++;
        if ({smp_valid, smp_data, overrun} !== {1'b1, 8'h81, 1'b1}) begin
            fails++;
            $display("FAIL bp_frozen: valid=%b data=%h ovr=%b want 1 81 1", smp_valid, smp_data, overrun);
        end
        cyc();
        tests++;
        if (smp_valid !== 1'b0) begin
            fails++; $display("FAIL bp_accept: valid=%b want 0", smp_valid);
        end
        cyc();
        tests++;
        if ({smp_valid, smp_data, overrun} !== {1'b1, 8'h84, 1'b1}) begin
            fails++;
            $display("FAIL bp_resume: valid=%b data=%h ovr=%b want 1 84 1", smp_valid, smp_data, overrun);
        end
    endtask

    task automatic test_enable_period0();
        logic [7:0] want;
        mode = 2'b01; step = 8'h01; period = 16'd0; smp_ready = 1'b1;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            want = 8'h80 + 8'(i);
            tests++;
            if ({smp_valid, smp_data} !== {1'b1, want}) begin
                fails++;
                $display("FAIL p0_code[%0d]: valid=%b data=%h want 1 %h", i, smp_valid, smp_data, want);
            end
        end
        en = 1'b0; smp_ready = 1'b0;
        cyc(); cyc();
        tests++;
        if ({smp_valid, smp_data} !== {1'b1, 8'h83}) begin
            fails++; $display("FAIL en0_pending: valid=%b data=%h want 1 83", smp_valid, smp_data);
        end
        smp_ready = 1'b1;
        cyc();
        tests++;
        if ({smp_valid, smp_data} !== {1'b0, 8'h83}) begin
            fails++; $display("FAIL en0_accept: valid=%b data=%h want 0 83", smp_valid, smp_data);
        end
        cyc(); cyc();
        tests++;
        if ({smp_valid, smp_data} !== {1'b0, 8'h83}) begin
            fails++; $display("FAIL en0_idle: valid=%b data=%h want 0 83", smp_valid, smp_data);
        end
        period = 16'd3; en = 1'b1;
        repeat (2) cyc();
        tests++;
        if (smp_valid !== 1'b0) begin
            fails++; $display("FAIL en1_early: valid=%b want 0", smp_valid);
        end
        cyc();
        tests++;
        if ({smp_valid, smp_data, overrun} !== {1'b1, 8'h84, 1'b0}) begin
            fails++;
            $display("FAIL en1_first: valid=%b data=%h ovr=%b want 1 84 0", smp_valid, smp_data, overrun);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; step = 8'h00; level = 8'h00;
        period = 16'd1; smp_ready = 1'b0;
        test_reset();
        test_sawtooth();
        test_triangle();
        test_square_const();
        test_back_to_back_overrun();
        test_enable_period0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
